// File: rtl/l2cache_req_arbiter.sv
// l2cache_req_arbiter
//   Front-end arbiter/sequencer for the L2 cache main FSM. Shares the single
//   L2 request port between icache reads, dcache reads/writes (including
//   strongly-ordered) and pipeline cache-maintenance ops. One issue is in
//   flight at a time, and every grant returns through IDLE. An icache request
//   that has been passed over MAX_WAIT times by dcache grants is forced next.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   i_req/i_addr/i_addr_ok     icache read request, held until i_addr_ok
//   d_req/d_we/d_suc/d_addr/
//   d_wdata/d_addr_ok          dcache request, held until d_addr_ok
//   op_req/op_code/op_addr/
//   op_done                    cache-op request, held until op_done pulse
//   l2_from                    00 none, 01 icache rd, 10 dcache rd, 11 dcache wr
//   l2_addr/l2_wdata/l2_suc    request fields latched at grant
//   l2_opflag                  one-cycle op issue pulse
//   l2_opcode/l2_opaddr        op fields latched at grant
//   l2_icache_addr_ok,
//   l2_dcache_addr_ok          L2 accepted the tagged request
//   l2_op_ready                L2 main FSM is idle
//
// Build option
//   L2ARB_PERF_CNT_EN          adds CNT_WIDTH-wide counters cnt_i_grant,
//                              cnt_d_grant, cnt_op and cnt_stall (wrapping).
//
// i_addr_ok, d_addr_ok and op_done follow the L2 handshake in the same cycle,
// so they are decoded from the registered state rather than registered.
module l2cache_req_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 4
`ifdef L2ARB_PERF_CNT_EN
  ,
  parameter int unsigned CNT_WIDTH  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  // icache
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_addr_ok,
  // dcache
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic                  d_suc,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_addr_ok,
  // cache maintenance ops
  input  logic                  op_req,
  input  logic [31:0]           op_code,
  input  logic [ADDR_WIDTH-1:0] op_addr,
  output logic                  op_done,
  // L2 request port
  output logic [1:0]            l2_from,
  output logic [ADDR_WIDTH-1:0] l2_addr,
  output logic [DATA_WIDTH-1:0] l2_wdata,
  output logic                  l2_suc,
  output logic                  l2_opflag,
  output logic [31:0]           l2_opcode,
  output logic [ADDR_WIDTH-1:0] l2_opaddr,
  input  logic                  l2_icache_addr_ok,
  input  logic                  l2_dcache_addr_ok,
  input  logic                  l2_op_ready
`ifdef L2ARB_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  cnt_i_grant,
  output logic [CNT_WIDTH-1:0]  cnt_d_grant,
  output logic [CNT_WIDTH-1:0]  cnt_op,
  output logic [CNT_WIDTH-1:0]  cnt_stall
`endif
);

  localparam int unsigned STARVE_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_I  = 3'd1,
    ISSUE_D  = 3'd2,
    OP_PULSE = 3'd3,
    OP_BUSY  = 3'd4
  } state_t;

  state_t              state;
  logic [STARVE_W-1:0] starve_cnt;
  logic                busy_armed;   // set after the ignored first OP_BUSY cycle

  logic starved;
  logic pick_op;
  logic pick_i;
  logic pick_d;
  logic i_ack;
  logic d_ack;
  logic op_fin;

  // Arbitration in IDLE: ready op, starved icache, dcache, icache.
  assign starved = (starve_cnt == STARVE_W'(MAX_WAIT));
  assign pick_op = op_req && l2_op_ready;
  assign pick_i  = !pick_op && i_req && (starved || !d_req);
  assign pick_d  = !pick_op && !pick_i && d_req;

  // Handshakes only count in the matching state; reset aborts them.
  assign i_ack  = !rst && (state == ISSUE_I) && l2_icache_addr_ok;
  assign d_ack  = !rst && (state == ISSUE_D) && l2_dcache_addr_ok;
  assign op_fin = !rst && (state == OP_BUSY) && busy_armed && l2_op_ready;

  assign i_addr_ok = i_ack;
  assign d_addr_ok = d_ack;
  assign op_done   = op_fin;

  // Sequencer: state, latched request fields and registered L2 strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      busy_armed <= 1'b0;
      l2_from    <= 2'b00;
      l2_opflag  <= 1'b0;
      l2_addr    <= '0;
      l2_wdata   <= '0;
      l2_suc     <= 1'b0;
      l2_opcode  <= '0;
      l2_opaddr  <= '0;
    end else begin
      l2_opflag <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_op) begin
            state     <= OP_PULSE;
            l2_opflag <= 1'b1;
            l2_opcode <= op_code;
            l2_opaddr <= op_addr;
          end else if (pick_i) begin
            state   <= ISSUE_I;
            l2_from <= 2'b01;
            l2_addr <= i_addr;
            // icache fetches are never strongly ordered
            l2_suc  <= 1'b0;
          end else if (pick_d) begin
            state    <= ISSUE_D;
            l2_from  <= {1'b1, d_we};
            l2_addr  <= d_addr;
            l2_wdata <= d_wdata;
            l2_suc   <= d_suc;
          end
        end

        ISSUE_I: begin
          if (l2_icache_addr_ok) begin
            state      <= IDLE;
            l2_from    <= 2'b00;
            starve_cnt <= '0;
          end
        end

        // No timeout: strongly-ordered writes may be held off indefinitely.
        ISSUE_D: begin
          if (l2_dcache_addr_ok) begin
            state   <= IDLE;
            l2_from <= 2'b00;
            if (i_req && !starved) begin
              starve_cnt <= starve_cnt + STARVE_W'(1);
            end
          end
        end

        OP_PULSE: begin
          state      <= OP_BUSY;
          busy_armed <= 1'b0;
        end

        // l2_op_ready in the first cycle still reflects the pre-op idle.
        OP_BUSY: begin
          busy_armed <= 1'b1;
          if (busy_armed && l2_op_ready) begin
            state      <= IDLE;
            busy_armed <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          l2_from <= 2'b00;
        end
      endcase
    end
  end

`ifdef L2ARB_PERF_CNT_EN
  logic stall;

  assign stall = ((state == ISSUE_I) && !l2_icache_addr_ok) ||
                 ((state == ISSUE_D) && !l2_dcache_addr_ok);

  // Free-running wrap-around event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_i_grant <= '0;
      cnt_d_grant <= '0;
      cnt_op      <= '0;
      cnt_stall   <= '0;
    end else begin
      if (i_ack)  cnt_i_grant <= cnt_i_grant + CNT_WIDTH'(1);
      if (d_ack)  cnt_d_grant <= cnt_d_grant + CNT_WIDTH'(1);
      if (op_fin) cnt_op      <= cnt_op + CNT_WIDTH'(1);
      if (stall)  cnt_stall   <= cnt_stall + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_l2cache_req_arbiter.sv
// Bench for l2cache_req_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_l2cache_req_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int          MW = 4;

  logic          clk;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_addr_ok;
  logic          d_req;
  logic          d_we;
  logic          d_suc;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_addr_ok;
  logic          op_req;
  logic [31:0]   op_code;
  logic [AW-1:0] op_addr;
  logic          op_done;
  logic [1:0]    l2_from;
  logic [AW-1:0] l2_addr;
  logic [DW-1:0] l2_wdata;
  logic          l2_suc;
  logic          l2_opflag;
  logic [31:0]   l2_opcode;
  logic [AW-1:0] l2_opaddr;
  logic          l2_icache_addr_ok;
  logic          l2_dcache_addr_ok;
  logic          l2_op_ready;
`ifdef L2ARB_PERF_CNT_EN
  logic [15:0]   cnt_i_grant;
  logic [15:0]   cnt_d_grant;
  logic [15:0]   cnt_op;
  logic [15:0]   cnt_stall;
`endif

  l2cache_req_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_WAIT   (MW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_req             (i_req),
    .i_addr            (i_addr),
    .i_addr_ok         (i_addr_ok),
    .d_req             (d_req),
    .d_we              (d_we),
    .d_suc             (d_suc),
    .d_addr            (d_addr),
    .d_wdata           (d_wdata),
    .d_addr_ok         (d_addr_ok),
    .op_req            (op_req),
    .op_code           (op_code),
    .op_addr           (op_addr),
    .op_done           (op_done),
    .l2_from           (l2_from),
    .l2_addr           (l2_addr),
    .l2_wdata          (l2_wdata),
    .l2_suc            (l2_suc),
    .l2_opflag         (l2_opflag),
    .l2_opcode         (l2_opcode),
    .l2_opaddr         (l2_opaddr),
    .l2_icache_addr_ok (l2_icache_addr_ok),
    .l2_dcache_addr_ok (l2_dcache_addr_ok),
    .l2_op_ready       (l2_op_ready)
`ifdef L2ARB_PERF_CNT_EN
    ,
    .cnt_i_grant       (cnt_i_grant),
    .cnt_d_grant       (cnt_d_grant),
    .cnt_op            (cnt_op),
    .cnt_stall         (cnt_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 icache, 2 dcache, 3 op),
  // how many cycles since the grant, and the times icache was passed over.
  int          m_who = 0;
  int          m_age = 0;
  int          m_starve = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic        m_suc = 1'b0;
  logic        m_we = 1'b0;
  logic [31:0] m_opcode = '0;
  logic [31:0] m_opaddr = '0;
  int          m_ci = 0;
  int          m_cd = 0;
  int          m_co = 0;
  int          m_cs = 0;

  // Outputs observed in the most recent cycle.
  logic       obs_iok;
  logic       obs_dok;
  logic       obs_done;
  logic       obs_flag;
  logic [1:0] obs_from;

  // One clock: compare at negedge+1, advance the model, retire acked requests.
  task automatic cycle();
    bit         e_iok;
    bit         e_dok;
    bit         e_done;
    bit         e_flag;
    logic [1:0] e_from;
    #1;
    e_iok  = !rst && m_who == 1 && l2_icache_addr_ok;
    e_dok  = !rst && m_who == 2 && l2_dcache_addr_ok;
    e_done = !rst && m_who == 3 && m_age >= 2 && l2_op_ready;
    e_flag = m_who == 3 && m_age == 0;
    e_from = (m_who == 1) ? 2'b01 : (m_who == 2) ? {1'b1, m_we} : 2'b00;

    obs_iok  = i_addr_ok;
    obs_dok  = d_addr_ok;
    obs_done = op_done;
    obs_flag = l2_opflag;
    obs_from = l2_from;

    check_val("l2_from",   64'(l2_from),   64'(e_from));
    check_val("l2_opflag", 64'(l2_opflag), 64'(e_flag));
    check_val("i_addr_ok", 64'(i_addr_ok), 64'(e_iok));
    check_val("d_addr_ok", 64'(d_addr_ok), 64'(e_dok));
    check_val("op_done",   64'(op_done),   64'(e_done));
    check_val("l2_addr",   64'(l2_addr),   64'(m_addr));
    check_val("l2_wdata",  64'(l2_wdata),  64'(m_wdata));
    check_val("l2_suc",    64'(l2_suc),    64'(m_suc));
    check_val("l2_opcode", 64'(l2_opcode), 64'(m_opcode));
    check_val("l2_opaddr", 64'(l2_opaddr), 64'(m_opaddr));
`ifdef L2ARB_PERF_CNT_EN
    check_val("cnt_i_grant", 64'(cnt_i_grant), 64'(m_ci % 65536));
    check_val("cnt_d_grant", 64'(cnt_d_grant), 64'(m_cd % 65536));
    check_val("cnt_op",      64'(cnt_op),      64'(m_co % 65536));
    check_val("cnt_stall",   64'(cnt_stall),   64'(m_cs % 65536));
`endif

    if (rst) begin
      m_who = 0; m_age = 0; m_starve = 0;
      m_addr = '0; m_wdata = '0; m_suc = 1'b0; m_we = 1'b0;
      m_opcode = '0; m_opaddr = '0;
      m_ci = 0; m_cd = 0; m_co = 0; m_cs = 0;
    end else if (m_who == 0) begin
      m_age = 0;
      if (op_req && l2_op_ready) begin
        m_who = 3; m_opcode = op_code; m_opaddr = op_addr;
      end else if (i_req && m_starve == MW) begin
        m_who = 1; m_addr = i_addr; m_suc = 1'b0;
      end else if (d_req) begin
        m_who = 2; m_addr = d_addr; m_wdata = d_wdata; m_suc = d_suc; m_we = d_we;
      end else if (i_req) begin
        m_who = 1; m_addr = i_addr; m_suc = 1'b0;
      end
    end else begin
      m_age++;
      if (m_who == 1) begin
        if (e_iok) begin m_who = 0; m_starve = 0; m_ci++; end
        else m_cs++;
      end else if (m_who == 2) begin
        if (e_dok) begin
          m_who = 0; m_cd++;
          if (i_req && m_starve < MW) m_starve++;
        end else m_cs++;
      end else if (e_done) begin
        m_who = 0; m_co++;
      end
    end

    @(posedge clk);
    @(negedge clk);
    if (e_iok)  i_req  = 1'b0;
    if (e_dok)  d_req  = 1'b0;
    if (e_done) op_req = 1'b0;
  endtask

  task automatic clear_inputs();
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_suc = 0; d_addr = '0; d_wdata = '0;
    op_req = 0; op_code = '0; op_addr = '0;
    l2_icache_addr_ok = 0; l2_dcache_addr_ok = 0; l2_op_ready = 1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  int         n_ok;
  int         ack_k;
  int         nd;
  int         pulse_at;
  int         done_at;
  int         n_flag;
  int         n_done;
  int         n_so;
  logic [1:0] fr[6];
  int         grants[$];

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    do_reset();

    // Single icache read, L2 acks two cycles after issue.
    i_req = 1; i_addr = 32'h1000;
    n_ok = 0; ack_k = -1;
    for (int k = 0; k < 6; k++) begin
      l2_icache_addr_ok = (m_who == 1 && m_age == 2);
      cycle();
      fr[k] = obs_from;
      if (obs_iok) begin n_ok++; ack_k = k; end
    end
    check_val("t1_ok_count", 64'(n_ok), 64'd1);
    check_val("t1_ack_cycle", 64'(ack_k), 64'd3);
    check_val("t1_from_issue", 64'(fr[1]), 64'd1);
    check_val("t1_from_after", 64'(fr[4]), 64'd0);

    // Contention and starvation: both requesters held, acks one cycle after issue.
    do_reset();
    d_we = 0; d_addr = 32'h2000; i_addr = 32'h1040;
    grants.delete();
    for (int k = 0; k < 100 && grants.size() < 10; k++) begin
      i_req = 1; d_req = 1;
      l2_icache_addr_ok = (m_who == 1 && m_age == 1);
      l2_dcache_addr_ok = (m_who == 2 && m_age == 1);
      cycle();
      if (obs_dok) grants.push_back(2);
      if (obs_iok) grants.push_back(1);
    end
    check_val("starve_grants", 64'(grants.size()), 64'd10);
    if (grants.size() == 10) begin
      check_val("contention_first", 64'(grants[0]), 64'd2);
      nd = 0;
      for (int j = 0; j < 4; j++) if (grants[j] == 2) nd++;
      check_val("starve_d_run1", 64'(nd), 64'd4);
      check_val("starve_i_first", 64'(grants[4]), 64'd1);
      nd = 0;
      for (int j = 5; j < 9; j++) if (grants[j] == 2) nd++;
      check_val("starve_d_run2", 64'(nd), 64'd4);
      check_val("starve_i_second", 64'(grants[9]), 64'd1);
    end

    // Cache op: L2 busy for 3 cycles after the pulse.
    do_reset();
    op_req = 1; op_code = 32'h10; op_addr = 32'h3;
    pulse_at = -1; done_at = -1; n_flag = 0; n_done = 0;
    for (int k = 0; k < 12; k++) begin
      l2_op_ready = !(pulse_at >= 0 && k > pulse_at && k <= pulse_at + 3);
      cycle();
      if (obs_flag) begin n_flag++; pulse_at = k; end
      if (obs_done) begin n_done++; done_at = k; end
    end
    check_val("op_flag_count", 64'(n_flag), 64'd1);
    check_val("op_done_count", 64'(n_done), 64'd1);
    check_val("op_done_delay", 64'(done_at - pulse_at), 64'd4);

    // Strongly-ordered write, ack withheld for 20 issue cycles.
    do_reset();
    d_req = 1; d_we = 1; d_suc = 1; d_addr = 32'h4000; d_wdata = 32'hDEADBEEF;
    cycle();
    n_so = 0;
    for (int k = 0; k < 20; k++) begin
      l2_dcache_addr_ok = (k == 19);
      cycle();
      if (obs_from == 2'b11) n_so++;
    end
    l2_dcache_addr_ok = 0;
    check_val("so_from_cycles", 64'(n_so), 64'd20);
    check_val("so_wdata", 64'(l2_wdata), 64'h0000_0000_DEAD_BEEF);
`ifdef L2ARB_PERF_CNT_EN
    check_val("so_cnt_stall", 64'(cnt_stall), 64'd19);
`endif

    // Reset while in ISSUE_D, then a stray dcache ack in IDLE.
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h5000; d_wdata = 32'h1234;
    cycle();
    cycle();
    rst = 1;
    cycle();
    rst = 0; d_req = 0;
    check_val("rst_from", 64'(l2_from), 64'd0);
    check_val("rst_addr", 64'(l2_addr), 64'd0);
    l2_dcache_addr_ok = 1;
    cycle();
    check_val("stray_dok", 64'(obs_dok), 64'd0);
    l2_dcache_addr_ok = 0;

    // Random traffic with occasional resets and stray acks.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if (!i_req && $urandom_range(3) == 0) begin
        i_req = 1; i_addr = $urandom;
      end
      if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1; d_we = 1'($urandom); d_suc = 1'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
      if (!op_req && $urandom_range(15) == 0) begin
        op_req = 1; op_code = $urandom; op_addr = $urandom;
      end
      l2_icache_addr_ok = ($urandom_range(2) == 0);
      l2_dcache_addr_ok = ($urandom_range(2) == 0);
      l2_op_ready       = ($urandom_range(3) != 0);
      rst               = ($urandom_range(299) == 0);
      cycle();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
